serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 157 +++++++++++++++
 tb/tb_serial_subtractor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: {borrow_out, Y} = A - B - borrow_in, one full-subtractor
// step per clock, LSB first, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             borrow_out_q, borrow_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       step_s;
  logic             last_s;
  logic [WIDTH-1:0] d_shift_s;

  // Returns {borrow, difference} of a single full-subtractor step.
  function automatic logic [1:0] fs_step(input logic a, input logic b, input logic bin);
    fs_step = {(~a & b) | (~(a ^ b) & bin), a ^ b ^ bin};
  endfunction

  always_comb begin
    step_s              = fs_step(a_sh_q[0], b_sh_q[0], br_q);
    last_s              = (cnt_q == CW'(WIDTH - 1));
    d_shift_s           = d_sh_q >> 1'b1;
    d_shift_s[WIDTH-1]  = step_s[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake flags are decoded from the next state so they leave flops directly.
  always_comb begin
    busy_d = (state_d == S_BUSY);
    done_d = (state_d == S_DONE);
  end

  always_comb begin
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    d_sh_d       = d_sh_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    y_d          = y_q;
    borrow_out_d = borrow_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d = A;
          b_sh_d = B;
          br_d   = borrow_in;
          cnt_d  = {CW{1'b0}};
          d_sh_d = {WIDTH{1'b0}};
        end else begin
          cnt_d  = cnt_q;
        end
      end
      S_BUSY: begin
        a_sh_d = a_sh_q >> 1'b1;
        b_sh_d = b_sh_q >> 1'b1;
        d_sh_d = d_shift_s;
        br_d   = step_s[1];
        cnt_d  = cnt_q + CW'(1'b1);
        // Results are published only once the final bit is in, never partially.
        if (last_s) begin
          y_d          = d_shift_s;
          borrow_out_d = step_s[1];
        end else begin
          y_d          = y_q;
        end
      end
      S_DONE:  cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q       <= {WIDTH{1'b0}};
      b_sh_q       <= {WIDTH{1'b0}};
      d_sh_q       <= {WIDTH{1'b0}};
      br_q         <= 1'b0;
      cnt_q        <= {CW{1'b0}};
      y_q          <= {WIDTH{1'b0}};
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      d_sh_q       <= d_sh_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
      y_q          <= y_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign Y          = y_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1 against an
// arithmetic reference model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, bin8, busy8, done8, bo8;
  logic [7:0] a8, b8, y8;
  logic       start1, a1, b1, bin1, busy1, done1, y1, bo1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_y8;
  logic       exp_bo8;
  logic       exp_y1, exp_bo1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .Y(y8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .borrow_in(bin1),
    .busy(busy1), .done(done1), .Y(y1), .borrow_out(bo1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain integer subtraction; bit w of the result is the final borrow.
  function automatic logic [32:0] ref_sub(input longint a, input longint b, input longint bin, input int w);
    longint d;
    logic [32:0] r;
    d = a - b - bin;
    r = 33'(d & ((64'sd1 <<< w) - 64'sd1));
    r[w] = (d < 0);
    return r;
  endfunction

  // mode 0: plain pulse; 1: disturb inputs/start during BUSY and DONE; 2: start held high
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin, input int mode);
    logic [32:0] r;
    r = ref_sub(longint'(a), longint'(b), longint'(bin), W);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("busy_first", 32'(busy8), 32'd1);
    chk("done_first", 32'(done8), 32'd0);
    if (mode != 2) start8 = 1'b0;
    for (int i = 1; i <= W; i++) begin
      if (mode == 1) begin
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); start8 = 1'b1;
      end
      @(negedge clk);
      if (i < W) begin
        chk("busy_mid", 32'(busy8), 32'd1);
        chk("done_mid", 32'(done8), 32'd0);
        chk("y_hold", 32'(y8), 32'(exp_y8));
        chk("bo_hold", 32'(bo8), 32'(exp_bo8));
      end
    end
    exp_y8  = r[7:0];
    exp_bo8 = r[8];
    chk("done_pulse", 32'(done8), 32'd1);
    chk("busy_at_done", 32'(busy8), 32'd0);
    chk("y_result", 32'(y8), 32'(exp_y8));
    chk("bo_result", 32'(bo8), 32'(exp_bo8));
    if (mode == 1) start8 = 1'b1;
    @(negedge clk);
    chk("done_drop", 32'(done8), 32'd0);
    chk("busy_idle", 32'(busy8), 32'd0);
    if (mode == 1) begin
      start8 = 1'b0;
      @(negedge clk);
      chk("no_extra_busy", 32'(busy8), 32'd0);
      chk("no_extra_done", 32'(done8), 32'd0);
      chk("y_kept", 32'(y8), 32'(exp_y8));
    end
  endtask

  task automatic run1(input logic a, input logic b, input logic bin);
    logic [32:0] r;
    r = ref_sub(longint'(a), longint'(b), longint'(bin), 1);
    a1 = a; b1 = b; bin1 = bin; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("w1_busy", 32'(busy1), 32'd1);
    chk("w1_y_hold", 32'(y1), 32'(exp_y1));
    start1 = 1'b0;
    @(negedge clk);
    exp_y1  = r[0];
    exp_bo1 = r[1];
    chk("w1_done", 32'(done1), 32'd1);
    chk("w1_busy_off", 32'(busy1), 32'd0);
    chk("w1_y", 32'(y1), 32'(exp_y1));
    chk("w1_bo", 32'(bo1), 32'(exp_bo1));
    @(negedge clk);
    chk("w1_done_drop", 32'(done1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    exp_y8 = 8'h00; exp_bo8 = 1'b0; exp_y1 = 1'b0; exp_bo1 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_y", 32'(y8), 32'd0);
    chk("rst_bo", 32'(bo8), 32'd0);
    chk("rst_w1_y", 32'(y1), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'h05, 8'h03, 1'b0, 0);
    run8(8'h00, 8'h01, 1'b0, 0);
    run8(8'hA5, 8'hA5, 1'b1, 0);
    run8(8'h05, 8'h03, 1'b0, 1);
    for (int k = 0; k < 3; k++) run8(8'h80, 8'h7F, 1'b0, 2);
    start8 = 1'b0;
    @(negedge clk);

    // Abort an operation at its fourth busy cycle.
    a8 = 8'hF0; b8 = 8'h0F; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_abort", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_y8 = 8'h00; exp_bo8 = 1'b0; exp_y1 = 1'b0; exp_bo1 = 1'b0;
    chk("abort_y", 32'(y8), 32'd0);
    chk("abort_bo", 32'(bo8), 32'd0);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_idle", 32'(busy8), 32'd0);
    run8(8'h10, 8'h01, 1'b0, 0);

    for (int k = 0; k < 20; k++) run8(8'($urandom), 8'($urandom), 1'($urandom), 0);

    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      run1(v[2], v[1], v[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
